// File: rtl/axi_rd_port_arbiter_pkg.sv
// Shared types and ID helpers for the read-port arbiter.
package axi_rd_port_arbiter_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } arb_state_e;

    // Place the port index in the low port_w bits, requester id above it.
    function automatic logic [31:0] id_encode(input logic [31:0] txn_id,
                                              input logic [31:0] port,
                                              input int          port_w);
        return (txn_id << port_w) | port;
    endfunction

    // Port index carried in the low port_w bits of an AXI id.
    function automatic logic [31:0] id_port(input logic [31:0] axi_id,
                                            input int          port_w);
        return axi_id & ((32'd1 << port_w) - 32'd1);
    endfunction

    // Requester id with the port index stripped off.
    function automatic logic [31:0] id_txn(input logic [31:0] axi_id,
                                           input int          port_w);
        return axi_id >> port_w;
    endfunction

endpackage

// File: rtl/axi_rd_port_arbiter_rr.sv
// Round-robin pick: first requesting port at or after the pointer.
module axi_rd_port_arbiter_rr #(
    parameter int NumPorts = 2,
    parameter int PortW    = 1
) (
    input  logic [NumPorts-1:0] req_i,
    input  logic [PortW-1:0]    rr_i,
    output logic                gnt_valid_o,
    output logic [PortW-1:0]    idx_o
);

    int j;

    // Scan ports starting at the pointer, wrapping once around.
    always_comb begin
        gnt_valid_o = 1'b0;
        idx_o       = '0;
        j           = 0;
        for (int k = 0; k < NumPorts; k++) begin
            j = (int'(rr_i) + k) % NumPorts;
            if (!gnt_valid_o && req_i[j]) begin
                gnt_valid_o = 1'b1;
                idx_o       = PortW'(j);
            end
        end
    end

endmodule

// File: rtl/axi_rd_port_arbiter.sv
// Shares one axi_shim read channel between several refill requesters.
// The winning request is registered and held until the shim grants it;
// R beats are steered back by the port index in the low id bits.
module axi_rd_port_arbiter
    import axi_rd_port_arbiter_pkg::*;
#(
    parameter  int NumPorts       = 2,
    parameter  int AxiIdWidth     = 4,
    parameter  int AxiNumWords    = 4,
    parameter  int MaxOutstanding = 2,
    localparam int PortW          = $clog2(NumPorts),
    localparam int BlenW          = $clog2(AxiNumWords),
    localparam int CntW           = $clog2(MaxOutstanding + 1),
    localparam int TxnIdW         = AxiIdWidth - PortW
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         clr_i,
    input  logic [NumPorts-1:0]          req_i,
    output logic [NumPorts-1:0]          gnt_o,
    input  logic [NumPorts*64-1:0]       addr_i,
    input  logic [NumPorts*BlenW-1:0]    blen_i,
    input  logic [NumPorts*2-1:0]        size_i,
    input  logic [NumPorts*TxnIdW-1:0]   id_i,
    output logic                         rd_req_o,
    input  logic                         rd_gnt_i,
    output logic [63:0]                  rd_addr_o,
    output logic [BlenW-1:0]             rd_blen_o,
    output logic [1:0]                   rd_size_o,
    output logic [AxiIdWidth-1:0]        rd_id_o,
    output logic                         rd_rdy_o,
    input  logic                         rd_valid_i,
    input  logic                         rd_last_i,
    input  logic [63:0]                  rd_data_i,
    input  logic [AxiIdWidth-1:0]        rd_id_i,
    input  logic                         rd_exokay_i,
    output logic [NumPorts-1:0]          valid_o,
    output logic                         last_o,
    output logic [63:0]                  data_o,
    output logic [TxnIdW-1:0]            id_o,
    output logic                         exokay_o,
    output logic                         busy_o,
    output logic                         err_o
);

    typedef struct packed {
        logic [63:0]           addr;
        logic [BlenW-1:0]      blen;
        logic [1:0]            size;
        logic [AxiIdWidth-1:0] id;
    } axi_rd_req_t;

    arb_state_e        state_q;
    axi_rd_req_t       req_q;
    logic [PortW-1:0]  rr_q;
    logic [CntW-1:0]   cnt_q [NumPorts];
    logic              err_q;

    axi_rd_req_t       port_req [NumPorts];
    logic [NumPorts-1:0] eligible;
    logic [NumPorts-1:0] inc;
    logic [NumPorts-1:0] dec;
    logic              win_valid;
    logic [PortW-1:0]  win_idx;
    logic [PortW-1:0]  rr_next;
    logic              capture;
    logic [PortW-1:0]  ret_port;
    logic              port_ok;
    logic [CntW-1:0]   cnt_ret;
    logic              stray;
    logic              beat_ok;
    logic              any_cnt;

    // Unpack the flat port buses and tag each id with its port index.
    always_comb begin
        for (int i = 0; i < NumPorts; i++) begin
            port_req[i].addr = addr_i[i*64 +: 64];
            port_req[i].blen = blen_i[i*BlenW +: BlenW];
            port_req[i].size = size_i[i*2 +: 2];
            port_req[i].id   = AxiIdWidth'(id_encode(32'(id_i[i*TxnIdW +: TxnIdW]),
                                                     32'(i), PortW));
            eligible[i]      = req_i[i] && (cnt_q[i] < CntW'(MaxOutstanding));
        end
    end

    axi_rd_port_arbiter_rr #(
        .NumPorts (NumPorts),
        .PortW    (PortW)
    ) u_rr (
        .req_i       (eligible),
        .rr_i        (rr_q),
        .gnt_valid_o (win_valid),
        .idx_o       (win_idx)
    );

    // A new request can be taken when idle, or in the cycle the shim
    // accepts the held one, which gives back-to-back issue.
    assign capture  = win_valid && ((state_q == ST_IDLE) || rd_gnt_i);
    assign rr_next  = (int'(win_idx) == NumPorts - 1) ? '0 : win_idx + 1'b1;
    assign ret_port = PortW'(id_port(32'(rd_id_i), PortW));

    generate
        if ((2 ** PortW) == NumPorts) begin : g_port_full
            assign port_ok = 1'b1;
        end else begin : g_port_part
            assign port_ok = int'(ret_port) < NumPorts;
        end
    endgenerate

    // Outstanding count of the port the returning beat claims to belong to.
    always_comb begin
        cnt_ret = '0;
        for (int i = 0; i < NumPorts; i++) begin
            if (ret_port == PortW'(i)) cnt_ret = cnt_q[i];
        end
    end

    // A beat for an unknown port or one with nothing in flight is dropped.
    assign stray   = rd_valid_i && (!port_ok || (cnt_ret == '0));
    assign beat_ok = rd_valid_i && !stray;

    // Grant pulses, beat steering and per-port counter deltas.
    always_comb begin
        gnt_o   = '0;
        valid_o = '0;
        inc     = '0;
        dec     = '0;
        any_cnt = 1'b0;
        for (int i = 0; i < NumPorts; i++) begin
            gnt_o[i]   = capture && (win_idx == PortW'(i));
            valid_o[i] = beat_ok && (ret_port == PortW'(i));
            inc[i]     = gnt_o[i];
            dec[i]     = valid_o[i] && rd_last_i;
            any_cnt    = any_cnt || (cnt_q[i] != '0);
        end
    end

    // Request FSM, payload register, rr pointer, counters and sticky error.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            req_q   <= '0;
            rr_q    <= '0;
            err_q   <= 1'b0;
            for (int i = 0; i < NumPorts; i++) cnt_q[i] <= '0;
        end else if (clr_i) begin
            state_q <= ST_IDLE;
            req_q   <= '0;
            rr_q    <= '0;
            err_q   <= 1'b0;
            for (int i = 0; i < NumPorts; i++) cnt_q[i] <= '0;
        end else begin
            if (capture) begin
                state_q <= ST_REQ;
                req_q   <= port_req[win_idx];
                rr_q    <= rr_next;
            end else if ((state_q == ST_REQ) && rd_gnt_i) begin
                state_q <= ST_IDLE;
            end
            for (int i = 0; i < NumPorts; i++) begin
                cnt_q[i] <= cnt_q[i] + CntW'(inc[i]) - CntW'(dec[i]);
            end
            if (stray) err_q <= 1'b1;
        end
    end

    assign rd_req_o  = (state_q == ST_REQ);
    assign rd_addr_o = req_q.addr;
    assign rd_blen_o = req_q.blen;
    assign rd_size_o = req_q.size;
    assign rd_id_o   = req_q.id;
    assign rd_rdy_o  = 1'b1;
    assign last_o    = rd_last_i;
    assign data_o    = rd_data_i;
    assign id_o      = TxnIdW'(id_txn(32'(rd_id_i), PortW));
    assign exokay_o  = rd_exokay_i;
    assign busy_o    = (state_q == ST_REQ) || any_cnt;
    assign err_o     = err_q;

endmodule

// File: tb/tb_axi_rd_port_arbiter.sv
// Scoreboard bench for axi_rd_port_arbiter (default parameters).
module tb_axi_rd_port_arbiter;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         clr_i;
    logic [1:0]   req_i;
    logic [1:0]   gnt_o;
    logic [127:0] addr_i;
    logic [3:0]   blen_i;
    logic [3:0]   size_i;
    logic [5:0]   id_i;
    logic         rd_req_o;
    logic         rd_gnt_i;
    logic [63:0]  rd_addr_o;
    logic [1:0]   rd_blen_o;
    logic [1:0]   rd_size_o;
    logic [3:0]   rd_id_o;
    logic         rd_rdy_o;
    logic         rd_valid_i;
    logic         rd_last_i;
    logic [63:0]  rd_data_i;
    logic [3:0]   rd_id_i;
    logic         rd_exokay_i;
    logic [1:0]   valid_o;
    logic         last_o;
    logic [63:0]  data_o;
    logic [2:0]   id_o;
    logic         exokay_o;
    logic         busy_o;
    logic         err_o;

    axi_rd_port_arbiter dut (
        .clk_i(clk_i), .rst_i(rst_i), .clr_i(clr_i),
        .req_i(req_i), .gnt_o(gnt_o), .addr_i(addr_i), .blen_i(blen_i),
        .size_i(size_i), .id_i(id_i),
        .rd_req_o(rd_req_o), .rd_gnt_i(rd_gnt_i), .rd_addr_o(rd_addr_o),
        .rd_blen_o(rd_blen_o), .rd_size_o(rd_size_o), .rd_id_o(rd_id_o),
        .rd_rdy_o(rd_rdy_o), .rd_valid_i(rd_valid_i), .rd_last_i(rd_last_i),
        .rd_data_i(rd_data_i), .rd_id_i(rd_id_i), .rd_exokay_i(rd_exokay_i),
        .valid_o(valid_o), .last_o(last_o), .data_o(data_o), .id_o(id_o),
        .exokay_o(exokay_o), .busy_o(busy_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [63:0] addr;
        logic [3:0]  id;
        logic [1:0]  blen;
    } iss_t;

    typedef struct {
        logic [1:0]  valid;
        logic [63:0] data;
        logic        last;
        logic [2:0]  id;
    } beat_t;

    iss_t  iss_q [$];
    beat_t beat_q [$];
    iss_t  iss_e;
    beat_t beat_e;
    int    checks = 0;
    int    errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk_i);
    endtask

    task automatic push_iss(input logic [63:0] a, input logic [3:0] id, input logic [1:0] bl);
        iss_t e;
        e.addr = a; e.id = id; e.blen = bl;
        iss_q.push_back(e);
    endtask

    // Drive one R beat; push the expected steered beat when it should pass.
    task automatic drive_beat(input logic [3:0] id, input logic [63:0] d, input logic last,
                              input logic [1:0] exp_valid);
        beat_t e;
        rd_valid_i = 1'b1;
        rd_id_i    = id;
        rd_data_i  = d;
        rd_last_i  = last;
        if (exp_valid != 2'b00) begin
            e.valid = exp_valid; e.data = d; e.last = last; e.id = id[3:1];
            beat_q.push_back(e);
        end
    endtask

    // Monitor: pops expectations whenever the DUT issues or returns a beat.
    always @(negedge clk_i) begin
        if (!rst_i) begin
            if (rd_req_o && rd_gnt_i) begin
                if (iss_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL issue_unexpected: addr 0x%0h id 0x%0h, expected none", rd_addr_o, rd_id_o);
                end else begin
                    iss_e = iss_q.pop_front();
                    chk("issue_addr", rd_addr_o, iss_e.addr);
                    chk("issue_id", 64'(rd_id_o), 64'(iss_e.id));
                    chk("issue_blen", 64'(rd_blen_o), 64'(iss_e.blen));
                end
            end
            if (valid_o != 2'b00) begin
                if (beat_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL beat_unexpected: valid 0x%0h, expected none", valid_o);
                end else begin
                    beat_e = beat_q.pop_front();
                    chk("beat_valid", 64'(valid_o), 64'(beat_e.valid));
                    chk("beat_data", data_o, beat_e.data);
                    chk("beat_last", 64'(last_o), 64'(beat_e.last));
                    chk("beat_id", 64'(id_o), 64'(beat_e.id));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time 0x%0h expected finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_i = 1'b1; clr_i = 1'b0; req_i = '0; addr_i = '0; blen_i = '0;
        size_i = '0; id_i = '0; rd_gnt_i = 1'b0; rd_valid_i = 1'b0;
        rd_last_i = 1'b0; rd_data_i = '0; rd_id_i = '0; rd_exokay_i = 1'b0;

        // Reset values
        at_neg();
        chk("rst_rd_req", 64'(rd_req_o), 0);
        chk("rst_gnt", 64'(gnt_o), 0);
        chk("rst_valid", 64'(valid_o), 0);
        chk("rst_busy", 64'(busy_o), 0);
        chk("rst_err", 64'(err_o), 0);
        chk("rst_rdy", 64'(rd_rdy_o), 1);
        chk("rst_addr", rd_addr_o, 0);
        next_cycle();
        rst_i = 1'b0;

        // Single burst, shim stalls five cycles
        req_i = 2'b01; addr_i[63:0] = 64'h8000_0000; blen_i[1:0] = 2'd3;
        size_i[1:0] = 2'd3; id_i[2:0] = 3'd5;
        at_neg();
        chk("t1_gnt", 64'(gnt_o), 64'h1);
        push_iss(64'h8000_0000, 4'hA, 2'd3);
        next_cycle();
        req_i = 2'b00;
        for (int k = 0; k < 5; k++) begin
            at_neg();
            chk("t1_hold_req", 64'(rd_req_o), 1);
            chk("t1_hold_addr", rd_addr_o, 64'h8000_0000);
            chk("t1_hold_id", 64'(rd_id_o), 64'hA);
            chk("t1_hold_gnt", 64'(gnt_o), 0);
            next_cycle();
        end
        rd_gnt_i = 1'b1;
        at_neg();
        next_cycle();
        rd_gnt_i = 1'b0;
        at_neg();
        chk("t1_req_drop", 64'(rd_req_o), 0);
        chk("t1_busy_inflight", 64'(busy_o), 1);
        for (int b = 0; b < 4; b++) begin
            next_cycle();
            drive_beat(4'hA, 64'h100 + 64'(b), b == 3, 2'b01);
            at_neg();
        end
        next_cycle();
        rd_valid_i = 1'b0; rd_last_i = 1'b0;
        at_neg();
        chk("t1_busy_done", 64'(busy_o), 0);
        chk("t1_err", 64'(err_o), 0);

        // Both ports continuously, shim always granting
        next_cycle();
        clr_i = 1'b1;
        next_cycle();
        clr_i = 1'b0;
        addr_i = {64'h2000, 64'h1000}; blen_i = '0; id_i = {3'd2, 3'd1};
        req_i = 2'b11; rd_gnt_i = 1'b1;
        begin
            logic [1:0] exp_g [5];
            exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01;
            exp_g[3] = 2'b10; exp_g[4] = 2'b00;
            for (int c = 0; c < 5; c++) begin
                at_neg();
                chk("t2_gnt", 64'(gnt_o), 64'(exp_g[c]));
                if (exp_g[c] == 2'b01) push_iss(64'h1000, 4'h2, 2'd0);
                if (exp_g[c] == 2'b10) push_iss(64'h2000, 4'h5, 2'd0);
                next_cycle();
            end
        end
        req_i = 2'b00; rd_gnt_i = 1'b0;
        at_neg();
        chk("t2_idle", 64'(rd_req_o), 0);

        // Outstanding limit on port 1
        next_cycle();
        drive_beat(4'h2, 64'h30, 1'b1, 2'b01);
        at_neg();
        next_cycle();
        drive_beat(4'h2, 64'h31, 1'b1, 2'b01);
        at_neg();
        next_cycle();
        rd_valid_i = 1'b0; rd_last_i = 1'b0;
        req_i = 2'b11;
        at_neg();
        chk("t3_p0_only", 64'(gnt_o), 64'h1);
        push_iss(64'h1000, 4'h2, 2'd0);
        next_cycle();
        req_i = 2'b10; rd_gnt_i = 1'b1;
        at_neg();
        chk("t3_p1_blocked", 64'(gnt_o), 0);
        next_cycle();
        rd_gnt_i = 1'b0;
        drive_beat(4'h5, 64'h40, 1'b1, 2'b10);
        at_neg();
        chk("t3_p1_still_blocked", 64'(gnt_o), 0);
        next_cycle();
        rd_valid_i = 1'b0; rd_last_i = 1'b0;
        at_neg();
        chk("t3_p1_regrant", 64'(gnt_o), 64'h2);
        push_iss(64'h2000, 4'h5, 2'd0);
        next_cycle();
        req_i = 2'b00; rd_gnt_i = 1'b1;
        at_neg();
        next_cycle();
        rd_gnt_i = 1'b0;

        // Capture and last beat on port 0 in the same cycle
        req_i = 2'b01;
        drive_beat(4'h2, 64'h50, 1'b1, 2'b01);
        at_neg();
        chk("t4_gnt", 64'(gnt_o), 64'h1);
        chk("t4_err", 64'(err_o), 0);
        push_iss(64'h1000, 4'h2, 2'd0);
        next_cycle();
        req_i = 2'b00; rd_valid_i = 1'b0; rd_last_i = 1'b0; rd_gnt_i = 1'b1;
        at_neg();
        next_cycle();
        rd_gnt_i = 1'b0;
        drive_beat(4'h2, 64'h51, 1'b1, 2'b01);
        at_neg();
        next_cycle();
        drive_beat(4'h5, 64'h60, 1'b1, 2'b10);
        at_neg();
        next_cycle();
        drive_beat(4'h5, 64'h61, 1'b1, 2'b10);
        at_neg();
        next_cycle();
        rd_valid_i = 1'b0; rd_last_i = 1'b0;
        at_neg();
        chk("t4_busy", 64'(busy_o), 0);
        chk("t4_err_after", 64'(err_o), 0);

        // Stray beat for port 1 with nothing in flight
        next_cycle();
        drive_beat(4'h1, 64'h70, 1'b1, 2'b00);
        at_neg();
        chk("t5_valid_dropped", 64'(valid_o), 0);
        next_cycle();
        rd_valid_i = 1'b0; rd_last_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            at_neg();
            chk("t5_err_sticky", 64'(err_o), 1);
            next_cycle();
        end

        // Async reset while a request is held
        addr_i[63:0] = 64'h3000;
        req_i = 2'b01;
        at_neg();
        chk("t6_gnt", 64'(gnt_o), 64'h1);
        next_cycle();
        req_i = 2'b00;
        at_neg();
        chk("t6_req_held", 64'(rd_req_o), 1);
        #2;
        rst_i = 1'b1;
        #1;
        chk("t6_rst_req", 64'(rd_req_o), 0);
        chk("t6_rst_err", 64'(err_o), 0);
        chk("t6_rst_busy", 64'(busy_o), 0);
        next_cycle();
        rst_i = 1'b0;
        req_i = 2'b11;
        at_neg();
        chk("t6_rr_reset", 64'(gnt_o), 64'h1);
        next_cycle();
        req_i = 2'b00;
        at_neg();

        chk("end_issue_queue", 64'(iss_q.size()), 0);
        chk("end_beat_queue", 64'(beat_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
